// File: rtl/encoder8_3_pkg.sv
// encoder8_3_pkg: shared constants for the 8-to-3 priority encoder.
//   IDX_W / NUM_IN : index width and number of request lines
//   IDX_Y7..IDX_Y0 : binary index code produced for each winning line
//   IDX_RST        : index value held in reset and when nothing is encoded
package encoder8_3_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NUM_IN = 8;

  localparam logic [IDX_W-1:0] IDX_Y7  = 3'd7;
  localparam logic [IDX_W-1:0] IDX_Y6  = 3'd6;
  localparam logic [IDX_W-1:0] IDX_Y5  = 3'd5;
  localparam logic [IDX_W-1:0] IDX_Y4  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_Y3  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_Y2  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_Y1  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_Y0  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_RST = 3'b000;

endpackage

// File: rtl/encoder8_3_prio_comb.sv
// encoder8_3_prio_comb: purely combinational next-state logic of the encoder.
// Optional feature macro: ENCODER8_3_MULTIHOT_ERR_EN (adds err_o).
//   en_i    : encoder enable, active high
//   y_i     : request lines, y_i[7] highest priority
//   idx_o   : next encoded index
//   valid_o : next valid flag (enabled and at least one request)
//   err_o   : next multi-hot flag (only with ENCODER8_3_MULTIHOT_ERR_EN)
module encoder8_3_prio_comb
  import encoder8_3_pkg::*;
(
  input  logic              en_i,
  input  logic [NUM_IN-1:0] y_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
  ,
  output logic              err_o
`endif
);

  always_comb begin
    idx_o   = IDX_RST;
    valid_o = 1'b0;
    if (!en_i) begin
      idx_o   = IDX_RST;
      valid_o = 1'b0;
    end else if (y_i[7]) begin
      idx_o   = IDX_Y7;
      valid_o = 1'b1;
    end else if (y_i[6]) begin
      idx_o   = IDX_Y6;
      valid_o = 1'b1;
    end else if (y_i[5]) begin
      idx_o   = IDX_Y5;
      valid_o = 1'b1;
    end else if (y_i[4]) begin
      idx_o   = IDX_Y4;
      valid_o = 1'b1;
    end else if (y_i[3]) begin
      idx_o   = IDX_Y3;
      valid_o = 1'b1;
    end else if (y_i[2]) begin
      idx_o   = IDX_Y2;
      valid_o = 1'b1;
    end else if (y_i[1]) begin
      idx_o   = IDX_Y1;
      valid_o = 1'b1;
    end else if (y_i[0]) begin
      idx_o   = IDX_Y0;
      valid_o = 1'b1;
    end
  end

`ifdef ENCODER8_3_MULTIHOT_ERR_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  logic [NUM_IN-1:0] y_minus_one;
  assign y_minus_one = y_i - NUM_IN'(1);
  assign err_o = en_i && ((y_i & y_minus_one) != '0);
`endif

endmodule

// File: rtl/encoder8_3_beh_ifelse.sv
// encoder8_3_beh_ifelse: 8-to-3 priority encoder with enable, valid flag and
// registered outputs (one cycle latency, synchronous active-high reset).
// Optional feature macro: ENCODER8_3_MULTIHOT_ERR_EN (adds registered err).
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : encoder enable
//   Y7..Y0     : request lines, Y7 highest priority
//   A2..A0     : registered encoded index
//   valid      : registered, en and at least one request
//   err        : registered, en and two or more requests (macro only)
module encoder8_3_beh_ifelse
  import encoder8_3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic Y7,
  input  logic Y6,
  input  logic Y5,
  input  logic Y4,
  input  logic Y3,
  input  logic Y2,
  input  logic Y1,
  input  logic Y0,
  output logic A2,
  output logic A1,
  output logic A0,
  output logic valid
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
  ,
  output logic err
`endif
);

  logic [NUM_IN-1:0] y;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic              valid_d, valid_q;

  assign y = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

`ifdef ENCODER8_3_MULTIHOT_ERR_EN
  logic err_d, err_q;
`endif

  encoder8_3_prio_comb u_prio_comb (
    .en_i    (en),
    .y_i     (y),
    .idx_o   (idx_d),
    .valid_o (valid_d)
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
    ,
    .err_o   (err_d)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= IDX_RST;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef ENCODER8_3_MULTIHOT_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`endif

  assign A2    = idx_q[2];
  assign A1    = idx_q[1];
  assign A0    = idx_q[0];
  assign valid = valid_q;

endmodule

// File: tb/tb_encoder8_3_beh_ifelse.sv
// tb_encoder8_3_beh_ifelse: directed self-checking bench for the encoder.
module tb_encoder8_3_beh_ifelse;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] y;
  logic       A2, A1, A0, valid;
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
  logic       err;
`endif

  int checks;
  int errors;

  encoder8_3_beh_ifelse dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .Y7    (y[7]),
    .Y6    (y[6]),
    .Y5    (y[5]),
    .Y4    (y[4]),
    .Y3    (y[3]),
    .Y2    (y[2]),
    .Y1    (y[1]),
    .Y0    (y[0]),
    .A2    (A2),
    .A1    (A1),
    .A0    (A0),
    .valid (valid)
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    y   = 8'h80;
    step();
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: A=%b valid=%b, want A=000 valid=0", {A2, A1, A0}, valid);
    end
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b, want 0", err);
    end
`endif
    rst = 1'b0;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b111 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: A=%b valid=%b, want A=111 valid=1", {A2, A1, A0}, valid);
    end
  endtask

  task automatic test_disabled();
    en = 1'b0;
    y  = 8'h80;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_y7: A=%b valid=%b, want A=000 valid=0", {A2, A1, A0}, valid);
    end
    y = 8'hFF;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_all: A=%b valid=%b, want A=000 valid=0", {A2, A1, A0}, valid);
    end
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL disabled_err: err=%b, want 0", err);
    end
`endif
  endtask

  task automatic test_onehot_sweep();
    logic [2:0] exp_idx [8] = '{3'b111, 3'b110, 3'b101, 3'b100,
                                3'b011, 3'b010, 3'b001, 3'b000};
    logic [7:0] vec     [8] = '{8'h80, 8'h40, 8'h20, 8'h10,
                                8'h08, 8'h04, 8'h02, 8'h01};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      y = vec[i];
      for (int k = 0; k < 2; k++) begin
        step();
        checks++;
        if ({A2, A1, A0} !== exp_idx[i] || valid !== 1'b1) begin
          errors++;
          $display("FAIL onehot y=%h edge%0d: A=%b valid=%b, want A=%b valid=1",
                   vec[i], k, {A2, A1, A0}, valid, exp_idx[i]);
        end
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL onehot_err y=%h: err=%b, want 0", vec[i], err);
        end
`endif
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] vec     [3] = '{8'b0100_1001, 8'b0010_0100, 8'hFF};
    logic [2:0] exp_idx [3] = '{3'b110, 3'b101, 3'b111};
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y = vec[i];
      step();
      checks++;
      if ({A2, A1, A0} !== exp_idx[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL priority y=%b: A=%b valid=%b, want A=%b valid=1",
                 vec[i], {A2, A1, A0}, valid, exp_idx[i]);
      end
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL priority_err y=%b: err=%b, want 1", vec[i], err);
      end
`endif
    end
  endtask

  task automatic test_no_request();
    en = 1'b1;
    y  = 8'h00;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL no_request: A=%b valid=%b, want A=000 valid=0", {A2, A1, A0}, valid);
    end
`ifdef ENCODER8_3_MULTIHOT_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL no_request_err: err=%b, want 0", err);
    end
`endif
  endtask

  task automatic test_midstream_reset();
    en = 1'b1;
    y  = 8'h10;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b100 || valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: A=%b valid=%b, want A=100 valid=1", {A2, A1, A0}, valid);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: A=%b valid=%b, want A=000 valid=0", {A2, A1, A0}, valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({A2, A1, A0} !== 3'b100 || valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_post: A=%b valid=%b, want A=100 valid=1", {A2, A1, A0}, valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = 1'b0;
    y      = 8'h00;
    test_reset();
    test_disabled();
    test_onehot_sweep();
    test_priority();
    test_no_request();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder8_3_beh_ifelse.md
Name: encoder8_3_beh_ifelse

Overview:
- 8-to-3 priority encoder with enable and registered outputs.
- Converts eight discrete request lines Y7..Y0 into a 3-bit binary index A2..A1..A0; Y7 has the highest priority.
- Adds a valid flag so downstream logic can tell "index 0 requested" apart from "nothing requested or disabled".
- Sits between discrete request/interrupt lines and a binary-index consumer.

Parameters:
- None. Width is fixed at 8 inputs and 3 index bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
- en  input  1  encoder enable; active high.
- Y7  input  1  request line 7 (highest priority).
- Y6  input  1  request line 6.
- Y5  input  1  request line 5.
- Y4  input  1  request line 4.
- Y3  input  1  request line 3.
- Y2  input  1  request line 2.
- Y1  input  1  request line 1.
- Y0  input  1  request line 0 (lowest priority).
- A2  output  1  encoded index bit 2 (MSB), registered.
- A1  output  1  encoded index bit 1, registered.
- A0  output  1  encoded index bit 0 (LSB), registered.
- valid  output  1  registered; 1 when en=1 and at least one Y is 1.

Behaviour:
- Reset: when rst=1 at a rising clk edge, {A2,A1,A0}=3'b000 and valid=0. Reset overrides en and all Y inputs.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N; outputs hold between edges.
- Combinational next-state is an ordered if-else chain from Y7 down to Y0. The highest set line wins:
  - Y7 -> 111, Y6 -> 110, Y5 -> 101, Y4 -> 100
  - Y3 -> 011, Y2 -> 010, Y1 -> 001, Y0 -> 000
  - Any line wins → next valid=1.
- en=0: next {A2,A1,A0}=000 and valid=0, regardless of Y.
- en=1 with all Y=0: next {A2,A1,A0}=000 and valid=0.
- Multiple Y lines set: only the highest-index set line is encoded. Example: Y5=1 and Y2=1 -> 101.
- X/Z inputs are not handled specially; the bench drives only 0/1.
- No other internal state; no handshake.
- Reset asserted mid-stream clears outputs on that edge. The first post-reset edge with rst=0 loads the encoded inputs normally.

Optional Feature:
- Macro: ENCODER8_3_MULTIHOT_ERR_EN.
- Defined: adds output port err (1 bit, registered, reset 0).
  - err=1 when en=1 and two or more Y lines are 1 in the same sample.
  - A2..A0 and valid still follow priority encoding.
  - err=0 when en=0.
- Not defined: no err port and no popcount logic. Behaviour is otherwise identical.

Decomposition:
- Shared package encoder8_3_pkg holds:
  - constants IDX_W=3 and NUM_IN=8
  - localparam index codes IDX_Y7..IDX_Y0 (3'd7..3'd0)
  - the reset value IDX_RST=3'b000
- One natural sub-module, encoder8_3_prio_comb: purely combinational. Takes en and Y[7:0]; produces next index, next valid and (under the macro) next err.
- The top level holds only the synchronous-reset registers.

Test Plan:
- Reset: rst=1 for 2 edges with en=1, Y7=1 -> A=000, valid=0. Release rst -> next edge A=111, valid=1.
- Disabled: en=0, Y7=1, others 0 -> after edge A=000, valid=0.
- One-hot sweep: en=1, drive Y7..Y0 one-hot in turn, each held ≥2 edges.
  - Each sample yields A=111,110,101,100,011,010,001,000, one cycle after the input change.
  - valid=1 throughout, including the Y0 case.
- Priority: en=1 with Y6=Y3=Y0=1 -> A=110, valid=1. With ENCODER8_3_MULTIHOT_ERR_EN defined, err=1.
- No request: en=1, all Y=0 -> A=000, valid=0, err=0.
- Mid-stream reset: en=1, Y4=1 gives A=100, valid=1. Pulse rst for one edge -> A=000, valid=0 on that edge. Next edge -> A=100, valid=1.
